// File: rtl/demux_1x2_pkg.sv
// Shared constants and helpers for the registered 1-to-2 demultiplexer.
// The optional per-channel counters are enabled by the DEMUX_1X2_CNT_EN macro.
package demux_1x2_pkg;

  localparam int DATA_W_DEF = 1;
  localparam int CNT_W      = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

  // Which output channel the current input cycle is steered to.
  typedef enum logic [1:0] {
    ROUTE_NONE = 2'd0,
    ROUTE_Y0   = 2'd1,
    ROUTE_Y1   = 2'd2
  } route_e;

  // An unknown select never resolves to a valid channel; it falls to ROUTE_NONE.
  function automatic route_e decode_route(input logic en, input logic s0);
    route_e r;
    r = ROUTE_NONE;
    if (en == 1'b1) begin
      case (s0)
        1'b0:    r = ROUTE_Y0;
        1'b1:    r = ROUTE_Y1;
        default: r = ROUTE_NONE;
      endcase
    end
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/demux_1x2_sat_cnt.sv
// Saturating event counter: counts cycles with inc high, sticks at CNT_MAX.
// Synchronous active-low clear.
module demux_1x2_sat_cnt
  import demux_1x2_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; reset is sampled on the clock edge, not asynchronously.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc) begin
      count <= sat_inc(count);
    end
  end

endmodule

// File: rtl/demux_1x2.sv
// Registered 1-to-2 demultiplexer with one cycle of latency and per-channel valid
// flags; define DEMUX_1X2_CNT_EN to add saturating valid-cycle counters cnt0/cnt1.
module demux_1x2
  import demux_1x2_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] In,
  input  logic              S0,
  output logic [DATA_W-1:0] Y0,
  output logic [DATA_W-1:0] Y1,
  output logic              V0,
  output logic              V1
`ifdef DEMUX_1X2_CNT_EN
  ,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1
`endif
);

  route_e            route;
  logic [DATA_W-1:0] y0_d;
  logic [DATA_W-1:0] y1_d;
  logic              v0_d;
  logic              v1_d;

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned (no latch), and the idle channel is forced to zero.
  always_comb begin
    y0_d  = '0;
    y1_d  = '0;
    v0_d  = 1'b0;
    v1_d  = 1'b0;
    route = decode_route(en, S0);
    case (route)
      ROUTE_Y0: begin
        y0_d = In;
        v0_d = 1'b1;
      end
      ROUTE_Y1: begin
        y1_d = In;
        v1_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Y0 <= '0;
      Y1 <= '0;
      V0 <= 1'b0;
      V1 <= 1'b0;
    end else begin
      Y0 <= y0_d;
      Y1 <= y1_d;
      V0 <= v0_d;
      V1 <= v1_d;
    end
  end

`ifdef DEMUX_1X2_CNT_EN
  // Counters watch the registered flags, so they trail V0/V1 by one edge.
  demux_1x2_sat_cnt u_cnt0 (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (V0),
    .count (cnt0)
  );

  demux_1x2_sat_cnt u_cnt1 (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (V1),
    .count (cnt1)
  );
`endif

endmodule

// File: tb/tb_demux_1x2.sv
// Directed self-checking bench for demux_1x2 (DATA_W=1); the counter section
// runs only when DEMUX_1X2_CNT_EN is defined.
module tb_demux_1x2;

  logic clk;
  logic rst_n;
  logic en;
  logic In;
  logic S0;
  logic Y0;
  logic Y1;
  logic V0;
  logic V1;
`ifdef DEMUX_1X2_CNT_EN
  logic [15:0] cnt0;
  logic [15:0] cnt1;
`endif

  int checks = 0;
  int errors = 0;

  demux_1x2 #(.DATA_W(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .In    (In),
    .S0    (S0),
    .Y0    (Y0),
    .Y1    (Y1),
    .V0    (V0),
    .V1    (V1)
`ifdef DEMUX_1X2_CNT_EN
    ,
    .cnt0  (cnt0),
    .cnt1  (cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs away from the edge, then sample just after it.
  task automatic drive(input logic r, input logic e, input logic i, input logic s);
    @(negedge clk);
    rst_n = r;
    en    = e;
    In    = i;
    S0    = s;
    @(posedge clk);
    #1;
  endtask

  // Expected value packed as {Y0, Y1, V0, V1}.
  task automatic check_out(input string tag, input logic [3:0] exp);
    check(tag, {28'd0, Y0, Y1, V0, V1}, {28'd0, exp});
  endtask

  // A routed cycle with an unknown select is a stimulus error.
  always @(posedge clk) begin
    if (rst_n === 1'b1 && en === 1'b1) begin
      assert (!$isunknown(S0))
      else begin
        errors++;
        $error("FAIL s0_unknown: observed %b expected 0 or 1", S0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    In    = 1'b1;
    S0    = 1'b1;

    drive(1'b0, 1'b1, 1'b1, 1'b1);
    check_out("reset_cycle1", 4'b0000);
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    check_out("reset_cycle2", 4'b0000);
`ifdef DEMUX_1X2_CNT_EN
    check("cnt0_reset", {16'd0, cnt0}, 32'd0);
    check("cnt1_reset", {16'd0, cnt1}, 32'd0);
`endif

    drive(1'b1, 1'b1, 1'b0, 1'b0);
    check_out("tt_in0_s0", 4'b0010);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    check_out("tt_in0_s1", 4'b0001);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    check_out("tt_in1_s0", 4'b1010);
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    check_out("tt_in1_s1", 4'b0101);

    drive(1'b1, 1'b0, 1'b1, 1'b0);
    check_out("en_off_s0", 4'b0000);
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    check_out("en_off_s1", 4'b0000);

    for (int k = 0; k < 8; k++) begin
      logic s;
      s = k[0];
      drive(1'b1, 1'b1, 1'b1, s);
      check_out($sformatf("alt_%0d", k), s ? 4'b0101 : 4'b1010);
      check($sformatf("alt_onehot_%0d", k), {31'd0, V0 & V1}, 32'd0);
    end

    drive(1'b1, 1'b1, 1'b1, 1'b0);
    check_out("mid_pre", 4'b1010);
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    check_out("mid_reset", 4'b0000);
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    check_out("mid_resume", 4'b0101);

`ifdef DEMUX_1X2_CNT_EN
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    check("cnt0_cleared", {16'd0, cnt0}, 32'd0);
    for (int k = 0; k < 70000; k++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0);
    end
    check("cnt0_saturated", {16'd0, cnt0}, 32'h0000_FFFF);
    check("cnt1_idle", {16'd0, cnt1}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_1x2.md
DEMUX_1X2 -- requirements
Module: demux_1x2

Interface
REQ-001 Parameter DATA_W, default 1: width of the data input and of each data output.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 en  input  1  routing enable; 1 = route In this cycle, 0 = idle.
REQ-005 In  input  DATA_W  data to be routed.
REQ-006 S0  input  1  select; 0 routes to Y0, 1 routes to Y1.
REQ-007 Y0  output  DATA_W  registered output channel 0.
REQ-008 Y1  output  DATA_W  registered output channel 1.
REQ-009 V0  output  1  registered flag; Y0 carries routed data.
REQ-010 V1  output  1  registered flag; Y1 carries routed data.

Function
REQ-011 Latency SHALL be exactly 1 clk cycle from sampled In/S0/en to Y0/Y1/V0/V1.
REQ-012 With en=1 and S0=0: next cycle Y0=In, V0=1, Y1=0, V1=0.
REQ-013 With en=1 and S0=1: next cycle Y1=In, V1=1, Y0=0, V0=0.
REQ-014 The unselected output SHALL be driven to all-zeros, never hold its old value.
REQ-015 With en=0: next cycle Y0=Y1=0 and V0=V1=0, regardless of In and S0.
REQ-016 X/Z on S0 while en=1 SHALL NOT be resolved to a valid route; the bench flags it as an error.
REQ-017 At most one of V0/V1 SHALL be 1 in any cycle.
REQ-018 Back-to-back changes of S0 on consecutive cycles SHALL switch channels each cycle with no dead cycle.

Reset
REQ-019 rst_n=0 sampled at a rising clk edge SHALL set Y0=Y1=0 and V0=V1=0 on that edge.
REQ-020 Reset SHALL override en, In and S0 in the same cycle.
REQ-021 Routing SHALL resume on the first edge with rst_n=1, using the inputs sampled at that edge.
REQ-022 Reset asserted mid-operation SHALL discard any in-flight routed data with no partial update.

Configuration
REQ-023 Macro DEMUX_1X2_CNT_EN, when defined, SHALL add outputs cnt0 and cnt1, each 16 bits wide.
REQ-024 With the macro defined, cnt0/cnt1 SHALL count cycles with V0/V1 asserted, saturating at 16'hFFFF, and reset to 0 with rst_n.
REQ-025 Without the macro, the counter ports and their logic SHALL be absent; all other behaviour is identical.

Structure
REQ-026 Package demux_1x2_pkg SHALL hold the DATA_W default, the CNT_W=16 constant and the saturation value.
REQ-027 One sub-module, demux_1x2_sat_cnt, SHALL implement the saturating counter; it is instantiated twice, only under DEMUX_1X2_CNT_EN.

Verification
REQ-028 Reset: rst_n=0 for 2 cycles with en=1, In=1, S0=1 -> Y0=Y1=0, V0=V1=0.
REQ-029 Exhaustive truth table at DATA_W=1, en=1, one cycle each, outputs checked one cycle later:
- (In,S0)=(0,0) -> Y0=0, Y1=0, V0=1.
- (0,1) -> Y0=0, Y1=0, V1=1.
- (1,0) -> Y0=1, Y1=0, V0=1.
- (1,1) -> Y0=0, Y1=1, V1=1.
REQ-030 Enable gating: en=0, In=1, S0=0 -> next cycle all outputs 0.
REQ-031 Alternating S0=0,1,0,1 with In=1 and en=1 -> V0/V1 toggle every cycle; never both 1.
REQ-032 Mid-stream reset: rst_n=0 for one cycle during routing -> outputs 0 that cycle; routing resumes the next cycle.
REQ-033 With DEMUX_1X2_CNT_EN defined: 70000 cycles of S0=0 with en=1 -> cnt0 holds 16'hFFFF and cnt1=0.
